// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_RESET = 2'd0,
        RF_CLEAR = 2'd1,
        RF_READY = 2'd2
    } rf_state_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_LANE_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_RD_PORTS = 2;

    // Returns 0 for an illegal lane split so the top can refuse to elaborate.
    function automatic int calc_nlanes(input int data_w, input int lane_w);
        if (lane_w <= 0 || (data_w % lane_w) != 0) begin
            return 0;
        end
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/regfile_lane.sv
// One lane-wide storage bank: single write port, RD_PORTS combinational read ports.
// Part of regfile_param (REGFILE_BYPASS_EN handled in the top).
module regfile_lane #(
    parameter int LANE_W   = 8,
    parameter int DEPTH    = 16,
    parameter int RD_PORTS = 2,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [LANE_W-1:0]          wdata,
    input  logic [RD_PORTS*AW-1:0]     raddr,
    output logic [RD_PORTS*LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem_q [DEPTH];

    // No reset on the array: the clear sequencer in the top zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rdata[p*LANE_W +: LANE_W] = mem_q[raddr[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with byte-lane writes and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RD_PORTS = DEF_RD_PORTS,
    localparam int NLANES  = calc_nlanes(DATA_W, LANE_W),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NLANES-1:0]          wr_be,
    input  logic [RD_PORTS*AW-1:0]     rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_drop,
    output rf_state_e                  dbg_state
);

    if (NLANES == 0) begin : g_bad_lane_split
        $error("regfile_param: DATA_W must be a nonzero multiple of LANE_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_param: DEPTH must be a power of 2 and at least 2");
    end

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          busy_q, busy_d;
    logic          wr_drop_q, wr_drop_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        wr_drop_d = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart mid-clear.
                wr_drop_d = |wr_be;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d   = RF_READY;
                    busy_d    = 1'b0;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    assign busy      = busy_q;
    assign wr_drop   = wr_drop_q;
    assign dbg_state = state_q;

    // Storage is only touched with rst_n high; a write racing clr_req still lands.
    logic clr_we;
    logic usr_ok;
    assign clr_we = rst_n && (state_q == RF_CLEAR);
    assign usr_ok = rst_n && (state_q == RF_READY);

    logic [NLANES-1:0][RD_PORTS*LANE_W-1:0] lane_rdata;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic              lane_we;
        logic [AW-1:0]     lane_waddr;
        logic [LANE_W-1:0] lane_wdata;

        assign lane_we    = clr_we | (usr_ok & wr_be[l]);
        assign lane_waddr = clr_we ? clr_idx_q : wr_addr;
        assign lane_wdata = clr_we ? '0 : wr_data[l*LANE_W +: LANE_W];

        regfile_lane #(
            .LANE_W  (LANE_W),
            .DEPTH   (DEPTH),
            .RD_PORTS(RD_PORTS),
            .AW      (AW)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we),
            .waddr(lane_waddr),
            .wdata(lane_wdata),
            .raddr(rd_addr),
            .rdata(lane_rdata[l])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int l = 0; l < NLANES; l++) begin
                if (!busy_q) begin
                    if (BYPASS && (rd_addr[p*AW +: AW] == wr_addr) && wr_be[l]) begin
                        rd_data[p*DATA_W + l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
                    end else begin
                        rd_data[p*DATA_W + l*LANE_W +: LANE_W] = lane_rdata[l][p*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default 16x16/2-port build plus a 32x32/4-port build).
// Compile with +define+REGFILE_BYPASS_EN to check the forwarding build.
module tb_regfile_param;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit EXP_BYPASS = 1'b1;
`else
    localparam bit EXP_BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        clr_req;
    logic        busy;
    logic        wr_drop;
    rf_state_e   dbg_state;

    // wide instance
    logic [4:0]   w_wr_addr;
    logic [31:0]  w_wr_data;
    logic [3:0]   w_wr_be;
    logic [19:0]  w_rd_addr;
    logic [127:0] w_rd_data;
    logic         w_clr_req;
    logic         w_busy;
    logic         w_wr_drop;
    rf_state_e    w_dbg_state;

    regfile_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .dbg_state(dbg_state)
    );

    regfile_param #(
        .DATA_W  (32),
        .LANE_W  (8),
        .DEPTH   (32),
        .RD_PORTS(4)
    ) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .wr_be    (w_wr_be),
        .rd_addr  (w_rd_addr),
        .rd_data  (w_rd_data),
        .clr_req  (w_clr_req),
        .busy     (w_busy),
        .wr_drop  (w_wr_drop),
        .dbg_state(w_dbg_state)
    );

    // ---------------- reference model ----------------
    logic [15:0] model_mem [16];
    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                            input logic [1:0] be);
        logic [15:0] r;
        r = old_v;
        if (be[0]) r[7:0]  = new_v[7:0];
        if (be[1]) r[15:8] = new_v[15:8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_be   = 2'b00;
        model_mem[a] = merge16(model_mem[a], d, be);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL reset_wide_busy got=%b exp=1", w_busy); end
        rst_n = 1'b1;
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if (busy !== 1'b1) break;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL reset_clear_len got=%0d exp=16", n); end
        checks++; if (dbg_state !== RF_READY) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, RF_READY); end
        model_clear();
        for (int a = 0; a < 16; a += 2) begin
            rd_addr = {4'(a + 1), 4'(a)};
            #1;
            checks++;
            if (rd_data !== {model_mem[a+1], model_mem[a]}) begin
                errors++; $display("FAIL reset_sweep a=%0d got=%h exp=%h", a, rd_data, {model_mem[a+1], model_mem[a]});
            end
        end
    endtask

    task automatic test_byte_lanes();
        do_write(4'd3, 16'hA5C3, 2'b11);
        do_write(4'd3, 16'h00FF, 2'b01);
        rd_addr = {4'd3, 4'd3};
        #1;
        checks++; if (rd_data !== {16'hA5FF, 16'hA5FF}) begin errors++; $display("FAIL lanes_lo got=%h exp=A5FFA5FF", rd_data); end
        do_write(4'd3, 16'h1200, 2'b10);
        #1;
        checks++; if (rd_data !== {16'h12FF, 16'h12FF}) begin errors++; $display("FAIL lanes_hi got=%h exp=12FF12FF", rd_data); end
        checks++; if (model_mem[3] !== 16'h12FF) begin errors++; $display("FAIL lanes_model got=%h exp=12FF", model_mem[3]); end
    endtask

    task automatic test_random();
        logic [3:0]  a, r0, r1;
        logic [15:0] d, e0, e1;
        logic [1:0]  be;
        repeat (150) begin
            a  = 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            r0 = 4'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
            wr_addr = a; wr_data = d; wr_be = be; rd_addr = {r1, r0};
            #1;
            e0 = (EXP_BYPASS && r0 == a) ? merge16(model_mem[r0], d, be) : model_mem[r0];
            e1 = (EXP_BYPASS && r1 == a) ? merge16(model_mem[r1], d, be) : model_mem[r1];
            checks++;
            if (rd_data !== {e1, e0}) begin
                errors++; $display("FAIL random_read a=%0d be=%b r0=%0d r1=%0d got=%h exp=%h", a, be, r0, r1, rd_data, {e1, e0});
            end
            tick();
            wr_be = 2'b00;
            model_mem[a] = merge16(model_mem[a], d, be);
            checks++;
            if (wr_drop !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL random_status got drop=%b busy=%b exp drop=0 busy=0", wr_drop, busy);
            end
        end
    endtask

    task automatic test_clr_req();
        int n;
        wr_addr = 4'd7; wr_data = 16'h1234; wr_be = 2'b11; clr_req = 1'b1;
        tick();
        wr_be = 2'b00; clr_req = 1'b0;
        model_clear();
        rd_addr = {4'd7, 4'd5};
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start got=%b exp=1", busy); end
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if (busy !== 1'b1) break;
            if (n == 1) begin
                checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clr_read_gated got=%h exp=0", rd_data); end
            end
            if (n == 3) begin
                wr_addr = 4'd5; wr_data = 16'hBEEF; wr_be = 2'b11;
            end
            if (n == 4) begin
                checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", wr_drop); end
                wr_be = 2'b00; clr_req = 1'b1;
            end
            if (n == 5) begin
                checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got=%b exp=0", wr_drop); end
                clr_req = 1'b0;
            end
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL clr_len got=%0d exp=16", n); end
        #1;
        checks++; if (rd_data !== {model_mem[7], model_mem[5]}) begin errors++; $display("FAIL clr_r7_r5 got=%h exp=0", rd_data); end
        for (int a = 0; a < 16; a += 2) begin
            rd_addr = {4'(a + 1), 4'(a)};
            #1;
            checks++;
            if (rd_data !== {model_mem[a+1], model_mem[a]}) begin
                errors++; $display("FAIL clr_sweep a=%0d got=%h exp=0", a, rd_data);
            end
        end
    endtask

    task automatic test_bypass();
        do_write(4'd2, 16'h0011, 2'b11);
        wr_addr = 4'd2; wr_data = 16'hAABB; wr_be = 2'b10;
        rd_addr = {4'd2, 4'd9};
        #1;
        checks++;
        if (rd_data[31:16] !== (EXP_BYPASS ? 16'hAA11 : 16'h0011)) begin
            errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data[31:16], EXP_BYPASS ? 16'hAA11 : 16'h0011);
        end
        tick();
        wr_be = 2'b00;
        model_mem[2] = merge16(model_mem[2], 16'hAABB, 2'b10);
        checks++; if (rd_data[31:16] !== 16'hAA11) begin errors++; $display("FAIL bypass_next_cycle got=%h exp=AA11", rd_data[31:16]); end
        checks++; if (rd_data[15:0] !== model_mem[9]) begin errors++; $display("FAIL bypass_other_port got=%h exp=%h", rd_data[15:0], model_mem[9]); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        for (int a = 0; a < 16; a++) do_write(4'(a), 16'($urandom) | 16'h0101, 2'b11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        model_clear();
        repeat (9) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b1 || wr_drop !== 1'b0) begin errors++; $display("FAIL midrst_status got busy=%b drop=%b exp busy=1 drop=0", busy, wr_drop); end
        rst_n = 1'b1;
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if (busy !== 1'b1) break;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL midrst_len got=%0d exp=16", n); end
        for (int a = 0; a < 16; a += 2) begin
            rd_addr = {4'(a + 1), 4'(a)};
            #1;
            checks++;
            if (rd_data !== {model_mem[a+1], model_mem[a]}) begin
                errors++; $display("FAIL midrst_sweep a=%0d got=%h exp=0", a, rd_data);
            end
        end
    endtask

    task automatic test_wide();
        int n;
        n = 0;
        while (w_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL wide_busy_timeout got=%b exp=0", w_busy); end
        w_wr_addr = 5'd31; w_wr_data = 32'hDEADBEEF; w_wr_be = 4'hF;
        tick();
        w_wr_be = 4'h0;
        w_rd_addr = {4{5'd31}};
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (w_rd_data[p*32 +: 32] !== 32'hDEADBEEF) begin
                errors++; $display("FAIL wide_port%0d got=%h exp=DEADBEEF", p, w_rd_data[p*32 +: 32]);
            end
        end
        w_wr_data = 32'h11223344; w_wr_be = 4'b0101;
        tick();
        w_wr_be = 4'h0;
        w_rd_addr = {5'd0, 5'd31, 5'd0, 5'd31};
        #1;
        checks++;
        if (w_rd_data !== {32'h0, 32'hDE22BE44, 32'h0, 32'hDE22BE44}) begin
            errors++; $display("FAIL wide_lanes got=%h exp=%h", w_rd_data, {32'h0, 32'hDE22BE44, 32'h0, 32'hDE22BE44});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_n = 1'b0; clr_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        w_wr_addr = '0; w_wr_data = '0; w_wr_be = '0; w_rd_addr = '0; w_clr_req = 1'b0;
        model_clear();
        test_reset();
        test_byte_lanes();
        test_random();
        test_clr_req();
        test_bypass();
        test_reset_mid_clear();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port register file with per-byte-lane write enables and a hardware clear sequencer. It replaces the fixed 16x16 two-port file in the processor datapath. Depth, data width, lane width and read-port count are configurable, and one write port is dedicated. After reset, and on request, a state machine zeroes every entry; `busy` is held high while it does so.

## Interface
- `DATA_W`, 16: register width in bits. Must be a multiple of `LANE_W`.
- `LANE_W`, 8: byte-lane width. `NLANES = DATA_W/LANE_W`.
- `DEPTH`, 16: number of registers. Must be a power of 2 and at least 2. `AW = $clog2(DEPTH)`.
- `RD_PORTS`, 2: number of independent read ports.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_addr` in AW: write index.
- `wr_data` in DATA_W: write data.
- `wr_be` in NLANES: per-lane write enable. Bit i writes `wr_data[i*LANE_W +: LANE_W]`.
- `rd_addr` in RD_PORTS*AW: packed read indices. Port p is `rd_addr[p*AW +: AW]`.
- `rd_data` out RD_PORTS*DATA_W: packed read data. Combinational from `rd_addr`.
- `clr_req` in 1: single-cycle request to re-clear the whole file.
- `busy` out 1: high while the clear sequence runs.
- `wr_drop` out 1: registered one-cycle pulse. Set when a write with nonzero `wr_be` is presented while `busy` is high.

## Operation
- FSM states:
  - RESET: `rst_n` low.
  - CLEAR: zeroing entries.
  - READY: normal operation.
- RESET: at any edge with `rst_n` low, the FSM goes to CLEAR, `clr_idx`=0, `busy`=1, `wr_drop`=0. While `rst_n` stays low, no entry is written and `clr_idx` holds 0.
- CLEAR, each edge with `rst_n` high:
  - Writes zero to all lanes of entry `clr_idx`, then increments `clr_idx`.
  - At `clr_idx == DEPTH-1` it writes the final zero and transitions to READY.
  - `clr_req` is ignored in CLEAR; there is no restart.
- READY:
  - Each lane with `wr_be[i]`=1 updates `mem[wr_addr]` lane i. Other lanes keep their value.
  - `clr_req`=1 moves the FSM to CLEAR with `clr_idx`=0. A write presented in the same cycle is still performed; the clear then overwrites it.
- Writes in CLEAR are discarded. `wr_drop` pulses the following cycle.
- Reads:
  - `rd_data` port p = `mem[rd_addr_p]`, combinational.
  - While `busy`=1, every read port returns 0, regardless of memory contents.
  - Several ports may read the same address.
- Same-cycle read of the address being written in READY: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- Reset mid-clear: the sequence restarts from index 0 once `rst_n` rises.
- Output reset values: `busy`=1, `wr_drop`=0, `rd_data`=0.

## Timing
- Write latency: data written at edge N is visible on `rd_data` after edge N, without bypass.
- Clear duration:
  - After the first edge with `rst_n` high, `busy` stays high for exactly DEPTH edges, then goes low (DEPTH=16: 16 cycles).
  - `clr_req` seen at edge N gives `busy`=1 from after edge N through edge N+DEPTH.
  - The first accepted write is at the edge where `busy` has just gone low.
- `wr_drop` is asserted for the one cycle after the edge that discarded the write.
- No read latency; the `rd_addr` to `rd_data` path is combinational.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In READY, a read port whose address equals `wr_addr` returns, per lane, `wr_data` where `wr_be[i]`=1, and the stored lane otherwise. The path is combinational, giving same-cycle forwarding.
  - Bypass is inactive while `busy`=1.
- Undefined: a same-cycle read returns the pre-write contents. Software and the pipeline must not rely on forwarding.

## Structure
- Package `regfile_pkg` holds:
  - the FSM state enum (`RF_RESET`, `RF_CLEAR`, `RF_READY`);
  - the default parameter constants;
  - a function that computes `NLANES` and checks `DATA_W % LANE_W == 0`. Elaboration fails otherwise.
- Sub-module `regfile_lane`: one LANE_W x DEPTH storage bank with one write port and RD_PORTS read ports. It is instantiated NLANES times. The top holds the FSM, the clear mux, the bypass and the output gating.

## Test plan
- Reset and clear: hold `rst_n` low for 3 cycles, then release. Expect `busy`=1 for 16 cycles, then 0. Every `rd_addr` in 0..15 reads 0000.
- Byte lanes:
  - Write R3=A5C3 with `wr_be`=11. Then write 00FF with `wr_be`=01. Expect R3=A5FF.
  - Write 1200 with `wr_be`=10. Expect R3=12FF.
- Dropped write: during clear, write R5=BEEF. Expect `wr_drop`=1 for one cycle. After `busy` falls, R5=0000.
- `clr_req` with a simultaneous write: write R7=1234 with `clr_req`=1. Expect `busy` high for 16 cycles, then R7=0000. A `clr_req` pulse mid-clear must not extend `busy`.
- Bypass: R2=0011, then present a write R2=AABB with `wr_be`=10 and read R2 on port 1 in the same cycle.
  - With `REGFILE_BYPASS_EN`: reads AA11.
  - Without: reads 0011.
  - Both builds read AA11 on the next cycle.
- Reset mid-clear: assert `rst_n` low at clear index 9, then release. Expect a fresh 16-cycle `busy` and all entries 0.
- `RD_PORTS`=4, `DEPTH`=32, `DATA_W`=32: write R31=DEADBEEF. All four ports reading 31 return DEADBEEF.
